// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target and its bus monitor.
//   ADDR_W  - width of an I2C target address
//   ACK     - sda level the receiver drives to acknowledge a byte
//   NACK    - sda level (released line) meaning "not acknowledged"
//   state_t - target protocol FSM states
package i2c_pkg;

  localparam int   ADDR_W = 7;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: brings scl/sda into the system clock domain and reports
// bus events. Usable by both target and initiator.
//   clk_i      - system clock (rising edge)
//   rst_ni     - asynchronous active-low reset
//   scl_i      - raw scl line
//   sda_i      - raw sda line
//   sda_o      - synchronized sda level
//   scl_rise_o - one-cycle pulse on a synchronized scl rising edge
//   scl_fall_o - one-cycle pulse on a synchronized scl falling edge
//   start_o    - one-cycle pulse: sda fell while scl high
//   stop_o     - one-cycle pulse: sda rose while scl high
module i2c_bus_monitor (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // Bit 1 carries scl, bit 0 carries sda.
  logic [1:0] line_raw;
  logic [1:0] line_sync;
  logic [1:0] line_prev;

  assign line_raw = {scl_i, sda_i};

  // Two synchronizer flops per line plus one history flop for edge detection.
  // Everything resets to 1 so an idle (pulled-up) bus produces no events.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic meta_q;
      logic sync_q;
      logic prev_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          meta_q <= 1'b1;
          sync_q <= 1'b1;
          prev_q <= 1'b1;
        end else begin
          meta_q <= line_raw[gi];
          sync_q <= meta_q;
          prev_q <= sync_q;
        end
      end

      assign line_sync[gi] = sync_q;
      assign line_prev[gi] = prev_q;
    end
  endgenerate

  assign sda_o      = line_sync[0];
  assign scl_rise_o = line_sync[1] & ~line_prev[1];
  assign scl_fall_o = ~line_sync[1] & line_prev[1];
  // scl must be high in both samples so a simultaneous scl/sda change is not
  // mistaken for a START or STOP.
  assign start_o    = line_sync[1] & line_prev[1] & line_prev[0] & ~line_sync[0];
  assign stop_o     = line_sync[1] & line_prev[1] & ~line_prev[0] & line_sync[0];

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) with a single 7-bit address. Oversamples the
// bus with sys_clk (>= 16x scl); never stretches scl.
//   sys_clk   - system clock (rising edge)
//   rst_n     - asynchronous active-low reset
//   scl       - I2C clock from the initiator (input only)
//   sda       - open-drain I2C data, driven only to 0 or z
//   rx_data   - last byte written by the initiator
//   rx_valid  - one-cycle pulse when rx_data updates
//   tx_data   - byte to return on a read; hold from tx_req to its load
//   tx_req    - one-cycle pulse requesting the next read byte
//   busy      - high between START and STOP
//   addressed - high from address match until next START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR = 7'h1A
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       addressed
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_monitor u_bus_monitor (
    .clk_i      (sys_clk),
    .rst_ni     (rst_n),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       drive_q, drive_d;       // 1 = pull sda low
  logic       rw_q, rw_d;             // R/W bit of the matched address byte
  logic       addressed_q, addressed_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic [7:0] byte_in;

  // Byte as it stands after shifting in the bit sampled on this rising edge.
  assign byte_in = {shift_q[6:0], sda_s};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      drive_q     <= 1'b0;
      rw_q        <= 1'b0;
      addressed_q <= 1'b0;
      busy_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      drive_q     <= drive_d;
      rw_q        <= rw_d;
      addressed_q <= addressed_d;
      busy_q      <= busy_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    drive_d     = drive_q;
    rw_d        = rw_q;
    addressed_d = addressed_q;
    busy_d      = busy_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;

    if (stop_det) begin
      state_d     = ST_IDLE;
      cnt_d       = 4'd0;
      drive_d     = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b0;
    end else if (start_det) begin
      // Also covers repeated START: any partial byte is simply abandoned.
      state_d     = ST_ADDR;
      cnt_d       = 4'd0;
      drive_d     = 1'b0;
      addressed_d = 1'b0;
      busy_d      = 1'b1;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR: begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              addressed_d = 1'b1;
              rw_d        = byte_in[0];
              tx_req_d    = byte_in[0];
              state_d     = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_WRITE: begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            rx_data_d  = byte_in;
            rx_valid_d = 1'b1;
            state_d    = ST_WRITE_ACK;
          end
        end
        ST_READ: begin
          if (cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_READ_ACK: begin
          // 9th rising edge: initiator's acknowledge of the byte we sent.
          cnt_d = 4'd0;
          if (sda_s == ACK) begin
            tx_req_d = 1'b1;
            state_d  = ST_READ;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR_ACK, ST_WRITE_ACK: begin
          // First falling edge opens the ACK slot, the second closes it.
          if (!drive_q) begin
            drive_d = 1'b1;
          end else begin
            drive_d = 1'b0;
            cnt_d   = 4'd0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d = ST_READ;
              shift_d = tx_data;
              drive_d = ~tx_data[7];
            end else begin
              state_d = ST_WRITE;
            end
          end
        end
        ST_READ: begin
          if (cnt_q == 4'd0) begin
            // Falling edge after an initiator ACK: start the next byte.
            shift_d = tx_data;
            drive_d = ~tx_data[7];
          end else if (cnt_q == 4'd8) begin
            drive_d = 1'b0;
            state_d = ST_READ_ACK;
          end else begin
            drive_d = ~shift_q[6];
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Gating with rst_n releases the line combinationally on reset assertion.
  assign sda       = (drive_q && rst_n) ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

  localparam int Q = 100;  // quarter of an scl period, in ns (sys_clk = 10 ns)

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       scl     = 1'b1;
  logic       m_low   = 1'b0;  // initiator pulls sda low
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic       addressed;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 sys_clk = ~sys_clk;

  i2c_target #(.DEV_ADDR(7'h1A)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .busy      (busy),
    .addressed (addressed)
  );

  int passed = 0;
  int total  = 0;
  int tx_req_cnt = 0;

  typedef struct {
    string nm;
    logic  b;
  } bit_exp_t;

  bit_exp_t   bit_exp_q[$];  // expected sda level in target-driven slots
  logic [7:0] rx_exp_q[$];   // expected written bytes
  logic [7:0] tx_src_q[$];   // bytes to hand out on tx_req (one per expected request)
  logic       chk_slot = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- monitors (scoreboard side) ----------------
  always @(negedge sys_clk) begin
    if (rx_valid) begin
      check("rx_valid expected", 32'(rx_exp_q.size() > 0), 32'd1);
      if (rx_exp_q.size() > 0) begin
        logic [7:0] e;
        e = rx_exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e));
        $display("rx byte %02h (expected %02h)", rx_data, e);
      end
    end
  end

  always @(negedge sys_clk) begin
    if (tx_req) begin
      tx_req_cnt++;
      check("tx_req expected", 32'(tx_src_q.size() > 0), 32'd1);
      if (tx_src_q.size() > 0) begin
        tx_data = tx_src_q.pop_front();
        $display("tx_req -> tx_data %02h", tx_data);
      end
    end
  end

  always @(posedge scl) begin
    if (chk_slot) begin
      #(Q);
      check("bit queue nonempty", 32'(bit_exp_q.size() > 0), 32'd1);
      if (bit_exp_q.size() > 0) begin
        bit_exp_t e;
        e = bit_exp_q.pop_front();
        check(e.nm, 32'(sda), 32'(e.b));
      end
    end
  end

  // ---------------- initiator tasks ----------------
  // Enters and leaves with scl low (Q after the falling edge).
  task automatic clk_bit(input logic b, input logic chk, input logic exp_b, input string nm);
    m_low    = chk ? 1'b0 : ~b;
    chk_slot = chk;
    if (chk) bit_exp_q.push_back('{nm, exp_b});
    #(Q) scl = 1'b1;
    #(2*Q) scl = 1'b0;
    chk_slot = 1'b0;
    #(Q);
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    #(Q) scl = 1'b1;
    #(Q) m_low = 1'b1;
    #(Q) scl = 1'b0;
    #(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    #(Q) scl = 1'b1;
    #(Q) m_low = 1'b0;
    #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, 1'b0, "");
    clk_bit(1'b1, 1'b1, exp_ack, nm);
    $display("wrote %02h, ack slot expected %0b", b, exp_ack);
  endtask

  task automatic read_byte(input logic [7:0] exp_b, input logic m_ack);
    for (int i = 7; i >= 0; i--) clk_bit(1'b1, 1'b1, exp_b[i], $sformatf("read bit %0d of %02h", i, exp_b));
    clk_bit(~m_ack, 1'b0, 1'b0, "");
    $display("read %02h expected, initiator %s", exp_b, m_ack ? "ACK" : "NACK");
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    #33;
    check("reset sda", 32'(sda), 32'd1);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset tx_req", 32'(tx_req), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset addressed", 32'(addressed), 32'd0);
    rst_n = 1'b1;
    #(4*Q);

    // Write 0x34, 0x1E, 0x00, STOP
    i2c_start();
    check("busy after start", 32'(busy), 32'd1);
    write_byte(8'h34, 1'b0, "wr addr ack");
    check("addressed after match", 32'(addressed), 32'd1);
    rx_exp_q.push_back(8'h1E);
    write_byte(8'h1E, 1'b0, "wr data1 ack");
    rx_exp_q.push_back(8'h00);
    write_byte(8'h00, 1'b0, "wr data2 ack");
    i2c_stop();
    #(Q);
    check("busy after stop", 32'(busy), 32'd0);
    check("addressed after stop", 32'(addressed), 32'd0);

    // Mismatched address 0x1B: NACK, all data ignored
    i2c_start();
    write_byte(8'h36, 1'b1, "wrong addr nack");
    check("addressed on mismatch", 32'(addressed), 32'd0);
    write_byte(8'h55, 1'b1, "ignored byte1 nack");
    write_byte(8'hAA, 1'b1, "ignored byte2 nack");
    i2c_stop();
    #(Q);

    // Read 0xA5 (ACK) then 0x3C (NACK)
    tx_req_cnt = 0;
    tx_src_q.push_back(8'hA5);
    tx_src_q.push_back(8'h3C);
    i2c_start();
    write_byte(8'h35, 1'b0, "rd addr ack");
    check("addressed on read", 32'(addressed), 32'd1);
    read_byte(8'hA5, 1'b1);
    read_byte(8'h3C, 1'b0);
    #(Q);
    check("sda released after nack", 32'(sda), 32'd1);
    i2c_stop();
    #(Q);
    check("tx_req count read", 32'(tx_req_cnt), 32'd2);

    // Partial write then repeated START into a read
    tx_req_cnt = 0;
    i2c_start();
    write_byte(8'h34, 1'b0, "partial addr ack");
    clk_bit(1'b1, 1'b0, 1'b0, "");
    clk_bit(1'b0, 1'b0, 1'b0, "");
    clk_bit(1'b1, 1'b0, 1'b0, "");
    tx_src_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'h35, 1'b0, "rs addr ack");
    read_byte(8'h5A, 1'b0);
    i2c_stop();
    #(Q);
    check("tx_req count rs", 32'(tx_req_cnt), 32'd1);

    // Reset during an address ACK slot
    i2c_start();
    write_byte(8'h34, 1'b0, "pre-reset addr ack");
    rx_exp_q.push_back(8'hC3);
    write_byte(8'hC3, 1'b0, "pre-reset data ack");
    i2c_start();
    for (int i = 7; i >= 0; i--) clk_bit(1'(8'h34 >> i), 1'b0, 1'b0, "");
    m_low = 1'b0;
    #20;
    check("ack before reset", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    check("reset mid-ack sda", 32'(sda), 32'd1);
    check("reset mid-ack rx_data", 32'(rx_data), 32'h00);
    check("reset mid-ack busy", 32'(busy), 32'd0);
    check("reset mid-ack addressed", 32'(addressed), 32'd0);
    check("reset mid-ack rx_valid", 32'(rx_valid), 32'd0);
    check("reset mid-ack tx_req", 32'(tx_req), 32'd0);
    #40 rst_n = 1'b1;
    #(Q) scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #(Q);
    i2c_stop();
    #(Q);

    // Next transaction accepted normally
    i2c_start();
    write_byte(8'h34, 1'b0, "post-reset addr ack");
    rx_exp_q.push_back(8'h77);
    write_byte(8'h77, 1'b0, "post-reset data ack");
    i2c_stop();
    #(Q);
    check("busy final", 32'(busy), 32'd0);

    check("rx queue drained", 32'(rx_exp_q.size()), 32'd0);
    check("tx queue drained", 32'(tx_src_q.size()), 32'd0);
    check("bit queue drained", 32'(bit_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
